// File: rtl/alu_seq_ctrl_if.sv
// Command, ALU-drive and result handshake bundle for alu_seq_ctrl.
// slave = sequencer side, master = command source / ALU / result sink side.
interface alu_seq_ctrl_if #(
  parameter int A_WIDTH   = 16,
  parameter int CNT_WIDTH = 8
);
  logic                 cmd_vld;
  logic                 cmd_rdy;
  logic [A_WIDTH-1:0]   cmd_a;
  logic [A_WIDTH-1:0]   cmd_b;
  logic [3:0]           cmd_fun;

  logic [A_WIDTH-1:0]   alu_a;
  logic [A_WIDTH-1:0]   alu_b;
  logic [3:0]           alu_fun;
  logic                 alu_en;
  logic [A_WIDTH-1:0]   alu_out;
  logic                 alu_out_valid;

  logic [A_WIDTH-1:0]   res_data;
  logic                 res_err;
  logic                 res_vld;
  logic                 res_rdy;

  logic                 busy;
  logic [CNT_WIDTH-1:0] op_cnt;

  modport slave (
    input  cmd_vld, cmd_a, cmd_b, cmd_fun, alu_out, alu_out_valid, res_rdy,
    output cmd_rdy, alu_a, alu_b, alu_fun, alu_en, res_data, res_err, res_vld,
           busy, op_cnt
  );

  modport master (
    output cmd_vld, cmd_a, cmd_b, cmd_fun, alu_out, alu_out_valid, res_rdy,
    input  cmd_rdy, alu_a, alu_b, alu_fun, alu_en, res_data, res_err, res_vld,
           busy, op_cnt
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Single-command ALU sequencer: IDLE -> ISSUE -> WAIT -> HOLD -> IDLE.
// Define ALU_SEQ_TIMEOUT_EN to add a 16-cycle WAIT timeout that returns an error result.
module alu_seq_ctrl #(
  parameter int A_WIDTH   = 16,
  parameter int CNT_WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_seq_ctrl_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [1:0]           state;
  logic [A_WIDTH-1:0]   alu_a;
  logic [A_WIDTH-1:0]   alu_b;
  logic [3:0]           alu_fun;
  logic [A_WIDTH-1:0]   res_data;
  logic                 res_vld;
  logic [CNT_WIDTH-1:0] op_cnt;
`ifdef ALU_SEQ_TIMEOUT_EN
  logic [3:0]           to_cnt;
  logic                 res_err;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_fun  <= 4'b0000;
      res_data <= '0;
      res_vld  <= 1'b0;
      op_cnt   <= '0;
`ifdef ALU_SEQ_TIMEOUT_EN
      to_cnt   <= 4'd0;
      res_err  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.cmd_vld) begin
            alu_a   <= bus.cmd_a;
            alu_b   <= bus.cmd_b;
            alu_fun <= bus.cmd_fun;
            state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          state <= S_WAIT;
`ifdef ALU_SEQ_TIMEOUT_EN
          to_cnt <= 4'd0;
`endif
        end
        S_WAIT: begin
          // A valid result in the same cycle as the timeout takes priority.
          if (bus.alu_out_valid) begin
            res_data <= bus.alu_out;
            res_vld  <= 1'b1;
            state    <= S_HOLD;
`ifdef ALU_SEQ_TIMEOUT_EN
            res_err  <= 1'b0;
          end else if (to_cnt == 4'hF) begin
            res_data <= '0;
            res_err  <= 1'b1;
            res_vld  <= 1'b1;
            state    <= S_HOLD;
          end else begin
            to_cnt   <= to_cnt + 4'd1;
`endif
          end
        end
        S_HOLD: begin
          // res_data deliberately keeps its last value after the handshake.
          if (bus.res_rdy) begin
            res_vld <= 1'b0;
            op_cnt  <= op_cnt + CNT_WIDTH'(1);
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_rdy  = (state == S_IDLE);
  assign bus.busy     = (state != S_IDLE);
  assign bus.alu_en   = (state == S_ISSUE);
  assign bus.alu_a    = alu_a;
  assign bus.alu_b    = alu_b;
  assign bus.alu_fun  = alu_fun;
  assign bus.res_data = res_data;
  assign bus.res_vld  = res_vld;
  assign bus.op_cnt   = op_cnt;
`ifdef ALU_SEQ_TIMEOUT_EN
  assign bus.res_err  = res_err;
`else
  assign bus.res_err  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scenario bench for alu_seq_ctrl: ALU model answers one cycle after alu_en,
// expected results are queued at command drive time and popped when res_vld rises.
module tb_alu_seq_ctrl;

  logic clk;
  logic rst_n;

  alu_seq_ctrl_if #(.A_WIDTH(16), .CNT_WIDTH(8)) bus ();

  alu_seq_ctrl #(.A_WIDTH(16), .CNT_WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] data;
    logic        err;
  } res_t;

  res_t sb_q[$];
  res_t exp_r;
  int   n_tests;
  int   n_fail;

  function automatic logic [15:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                         input logic [3:0] fun);
    case (fun)
      4'h0:    return a + b;
      4'h1:    return a - b;
      4'h2:    return a & b;
      4'h3:    return a | b;
      4'h4:    return a ^ b;
      default: return a;
    endcase
  endfunction

  // ALU model: sees alu_en in the issue cycle, drives valid for the following cycle.
  logic        alu_resp_en;
  logic        mdl_pend;
  logic        mdl_vld;
  logic [15:0] mdl_data;
  logic        inj_vld;
  logic [15:0] inj_data;

  assign bus.alu_out_valid = mdl_vld | inj_vld;
  assign bus.alu_out       = inj_vld ? inj_data : mdl_data;

  initial begin
    mdl_pend = 1'b0;
    mdl_vld  = 1'b0;
    mdl_data = 16'h0;
  end

  always @(negedge clk) begin
    mdl_vld = 1'b0;
    if (mdl_pend) begin
      mdl_vld  = 1'b1;
      mdl_pend = 1'b0;
    end
    if (alu_resp_en && bus.alu_en) begin
      mdl_pend = 1'b1;
      mdl_data = alu_fn(bus.alu_a, bus.alu_b, bus.alu_fun);
    end
  end

  task automatic wait_res(input int max, output bit ok);
    for (int k = 0; k < max && !bus.res_vld; k++) @(negedge clk);
    ok = bus.res_vld;
  endtask

  task automatic wait_cmd_rdy(input int max, output bit ok);
    for (int k = 0; k < max && !bus.cmd_rdy; k++) @(negedge clk);
    ok = bus.cmd_rdy;
  endtask

  task automatic drive_cmd(input logic [15:0] a, input logic [15:0] b, input logic [3:0] fun);
    bus.cmd_a   = a;
    bus.cmd_b   = b;
    bus.cmd_fun = fun;
    bus.cmd_vld = 1'b1;
    sb_q.push_back(res_t'{data: alu_fn(a, b, fun), err: 1'b0});
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #2;
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_tests++; if (bus.alu_en !== 1'b0) begin n_fail++; $display("FAIL reset_alu_en got %b want 0", bus.alu_en); end
    n_tests++; if (bus.res_vld !== 1'b0) begin n_fail++; $display("FAIL reset_res_vld got %b want 0", bus.res_vld); end
    n_tests++; if (bus.res_err !== 1'b0) begin n_fail++; $display("FAIL reset_res_err got %b want 0", bus.res_err); end
    n_tests++; if ({bus.alu_a, bus.alu_b, bus.alu_fun} !== 36'h0) begin n_fail++; $display("FAIL reset_alu_drive got %h/%h/%h want 0", bus.alu_a, bus.alu_b, bus.alu_fun); end
    n_tests++; if (bus.res_data !== 16'h0) begin n_fail++; $display("FAIL reset_res_data got %h want 0", bus.res_data); end
    n_tests++; if (bus.op_cnt !== 8'h0) begin n_fail++; $display("FAIL reset_op_cnt got %0d want 0", bus.op_cnt); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    n_tests++; if (bus.cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_rdy got %b want 1", bus.cmd_rdy); end
  endtask

  task automatic test_reset_in_wait;
    alu_resp_en = 1'b0;
    @(negedge clk);
    bus.cmd_a = 16'h1111; bus.cmd_b = 16'h2222; bus.cmd_fun = 4'h4; bus.cmd_vld = 1'b1;
    @(negedge clk); bus.cmd_vld = 1'b0;
    @(negedge clk);
    n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL rstwait_busy got %b want 1", bus.busy); end
    rst_n = 1'b0;
    #1;
    n_tests++; if (bus.cmd_rdy !== 1'b1 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL rstwait_idle got rdy=%b busy=%b want 1/0", bus.cmd_rdy, bus.busy); end
    n_tests++; if ({bus.alu_a, bus.alu_b, bus.alu_fun, bus.alu_en} !== 37'h0) begin n_fail++; $display("FAIL rstwait_alu got %h/%h/%h en=%b want 0", bus.alu_a, bus.alu_b, bus.alu_fun, bus.alu_en); end
    n_tests++; if ({bus.res_vld, bus.res_err, bus.res_data} !== 18'h0) begin n_fail++; $display("FAIL rstwait_res got vld=%b err=%b data=%h want 0", bus.res_vld, bus.res_err, bus.res_data); end
    n_tests++; if (bus.op_cnt !== 8'h0) begin n_fail++; $display("FAIL rstwait_op_cnt got %0d want 0", bus.op_cnt); end
    @(negedge clk); rst_n = 1'b1;
    inj_data = 16'hBEEF; inj_vld = 1'b1;
    @(negedge clk); inj_vld = 1'b0;
    n_tests++; if (bus.res_vld !== 1'b0 || bus.busy !== 1'b0 || bus.res_data !== 16'h0) begin n_fail++; $display("FAIL rstwait_late_valid got vld=%b busy=%b data=%h want 0/0/0", bus.res_vld, bus.busy, bus.res_data); end
    n_tests++; if (bus.op_cnt !== 8'h0) begin n_fail++; $display("FAIL rstwait_late_cnt got %0d want 0", bus.op_cnt); end
    alu_resp_en = 1'b1;
  endtask

  // Edge N accepts; alu_en during the cycle after N; res_vld first sampled high at edge N+3.
  task automatic test_basic;
    @(negedge clk);
    bus.res_rdy = 1'b0;
    drive_cmd(16'h0005, 16'h0003, 4'h0);
    @(negedge clk); bus.cmd_vld = 1'b0;
    n_tests++; if (bus.alu_en !== 1'b1 || bus.alu_a !== 16'h0005 || bus.alu_b !== 16'h0003) begin n_fail++; $display("FAIL basic_issue got en=%b a=%h b=%h want 1/0005/0003", bus.alu_en, bus.alu_a, bus.alu_b); end
    n_tests++; if (bus.cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL basic_cmd_rdy got %b want 0", bus.cmd_rdy); end
    @(negedge clk);
    n_tests++; if (bus.alu_en !== 1'b0 || bus.res_vld !== 1'b0) begin n_fail++; $display("FAIL basic_wait got en=%b vld=%b want 0/0", bus.alu_en, bus.res_vld); end
    @(negedge clk);
    n_tests++; if (bus.res_vld !== 1'b1) begin n_fail++; $display("FAIL basic_latency got vld=%b want 1", bus.res_vld); end
    exp_r = sb_q.pop_front();
    n_tests++; if (bus.res_data !== exp_r.data || bus.res_err !== exp_r.err) begin n_fail++; $display("FAIL basic_result got %h/%b want %h/%b", bus.res_data, bus.res_err, exp_r.data, exp_r.err); end
    bus.res_rdy = 1'b1;
    @(negedge clk); bus.res_rdy = 1'b0;
    n_tests++; if (bus.res_vld !== 1'b0 || bus.res_data !== 16'h0008) begin n_fail++; $display("FAIL basic_release got vld=%b data=%h want 0/0008", bus.res_vld, bus.res_data); end
    n_tests++; if (bus.op_cnt !== 8'd1) begin n_fail++; $display("FAIL basic_op_cnt got %0d want 1", bus.op_cnt); end
  endtask

  task automatic test_hold;
    bit ok;
    @(negedge clk);
    bus.res_rdy = 1'b0;
    drive_cmd(16'h1234, 16'h00FF, 4'h2);
    @(negedge clk);
    drive_cmd(16'h0007, 16'h0009, 4'h1);
    wait_res(10, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL hold_timeout got no res_vld want res_vld within 10 cycles"); end
    exp_r = sb_q.pop_front();
    n_tests++; if (bus.res_data !== exp_r.data || bus.res_err !== exp_r.err) begin n_fail++; $display("FAIL hold_result got %h/%b want %h/%b", bus.res_data, bus.res_err, exp_r.data, exp_r.err); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_tests++; if (bus.res_vld !== 1'b1 || bus.res_data !== exp_r.data) begin n_fail++; $display("FAIL hold_stable[%0d] got vld=%b data=%h want 1/%h", i, bus.res_vld, bus.res_data, exp_r.data); end
      n_tests++; if (bus.cmd_rdy !== 1'b0 || bus.alu_a !== 16'h1234) begin n_fail++; $display("FAIL hold_no_accept[%0d] got rdy=%b a=%h want 0/1234", i, bus.cmd_rdy, bus.alu_a); end
    end
    bus.res_rdy = 1'b1;
    @(negedge clk); bus.res_rdy = 1'b0;
    n_tests++; if (bus.res_vld !== 1'b0 || bus.cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL hold_release got vld=%b rdy=%b want 0/1", bus.res_vld, bus.cmd_rdy); end
    @(negedge clk); bus.cmd_vld = 1'b0;
    n_tests++; if (bus.alu_a !== 16'h0007 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL hold_pending_accept got a=%h busy=%b want 0007/1", bus.alu_a, bus.busy); end
    bus.res_rdy = 1'b1;
    wait_res(10, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL hold_second_timeout got no res_vld want res_vld within 10 cycles"); end
    exp_r = sb_q.pop_front();
    n_tests++; if (bus.res_data !== exp_r.data || bus.res_err !== exp_r.err) begin n_fail++; $display("FAIL hold_second got %h/%b want %h/%b", bus.res_data, bus.res_err, exp_r.data, exp_r.err); end
    @(negedge clk); bus.res_rdy = 1'b0;
    n_tests++; if (bus.op_cnt !== 8'd3) begin n_fail++; $display("FAIL hold_op_cnt got %0d want 3", bus.op_cnt); end
  endtask

  task automatic test_back_to_back;
    bit ok;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    bus.res_rdy = 1'b1;
    drive_cmd(16'($urandom), 16'($urandom), 4'($urandom_range(0, 7)));
    for (int i = 0; i < 256; i++) begin
      wait_cmd_rdy(8, ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL b2b_rdy_timeout[%0d] got cmd_rdy=0 want 1", i); end
      @(negedge clk);
      n_tests++; if (bus.alu_en !== 1'b1) begin n_fail++; $display("FAIL b2b_en_rise[%0d] got %b want 1", i, bus.alu_en); end
      if (i < 255) drive_cmd(16'($urandom), 16'($urandom), 4'($urandom_range(0, 7)));
      else bus.cmd_vld = 1'b0;
      @(negedge clk);
      n_tests++; if (bus.alu_en !== 1'b0) begin n_fail++; $display("FAIL b2b_en_width[%0d] got %b want 0", i, bus.alu_en); end
      wait_res(8, ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL b2b_res_timeout[%0d] got no res_vld want 1", i); end
      exp_r = sb_q.pop_front();
      n_tests++; if (bus.res_data !== exp_r.data || bus.res_err !== exp_r.err) begin n_fail++; $display("FAIL b2b_result[%0d] got %h/%b want %h/%b", i, bus.res_data, bus.res_err, exp_r.data, exp_r.err); end
      n_tests++; if (bus.op_cnt !== 8'(i)) begin n_fail++; $display("FAIL b2b_op_cnt[%0d] got %0d want %0d", i, bus.op_cnt, i); end
    end
    @(negedge clk);
    n_tests++; if (bus.op_cnt !== 8'd0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_wrap got cnt=%0d busy=%b want 0/0", bus.op_cnt, bus.busy); end
    bus.res_rdy = 1'b0;
  endtask

  task automatic test_timeout;
    bit ok;
    alu_resp_en = 1'b0;
    @(negedge clk);
    bus.cmd_a = 16'hAAAA; bus.cmd_b = 16'h5555; bus.cmd_fun = 4'h0; bus.cmd_vld = 1'b1;
    @(negedge clk); bus.cmd_vld = 1'b0;
    @(negedge clk);
`ifdef ALU_SEQ_TIMEOUT_EN
    sb_q.push_back(res_t'{data: 16'h0, err: 1'b1});
    for (int k = 0; k < 15; k++) begin
      n_tests++; if (bus.res_vld !== 1'b0) begin n_fail++; $display("FAIL timeout_early[%0d] got vld=%b want 0", k, bus.res_vld); end
      @(negedge clk);
    end
    wait_res(4, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL timeout_never got no res_vld want 1"); end
`else
    repeat (100) @(negedge clk);
    n_tests++; if (bus.busy !== 1'b1 || bus.res_vld !== 1'b0 || bus.cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL no_timeout_wait got busy=%b vld=%b rdy=%b want 1/0/0", bus.busy, bus.res_vld, bus.cmd_rdy); end
    n_tests++; if (bus.alu_en !== 1'b0 || bus.res_err !== 1'b0) begin n_fail++; $display("FAIL no_timeout_en got en=%b err=%b want 0/0", bus.alu_en, bus.res_err); end
    inj_data = 16'h5A5A; inj_vld = 1'b1;
    sb_q.push_back(res_t'{data: 16'h5A5A, err: 1'b0});
    @(negedge clk); inj_vld = 1'b0;
    wait_res(4, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL no_timeout_release got no res_vld want 1"); end
`endif
    exp_r = sb_q.pop_front();
    n_tests++; if (bus.res_data !== exp_r.data || bus.res_err !== exp_r.err) begin n_fail++; $display("FAIL timeout_result got %h/%b want %h/%b", bus.res_data, bus.res_err, exp_r.data, exp_r.err); end
    bus.res_rdy = 1'b1;
    @(negedge clk); bus.res_rdy = 1'b0;
    n_tests++; if (bus.op_cnt !== 8'd1 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL timeout_done got cnt=%0d busy=%b want 1/0", bus.op_cnt, bus.busy); end
    alu_resp_en = 1'b1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    bus.cmd_vld = 1'b0; bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_fun = '0;
    bus.res_rdy = 1'b0;
    alu_resp_en = 1'b1;
    inj_vld = 1'b0; inj_data = '0;
    test_reset();
    test_reset_in_wait();
    test_basic();
    test_hold();
    test_back_to_back();
    test_timeout();
    n_tests++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain got %0d left want 0", sb_q.size()); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no completion want finish before 500us");
    $fatal(1, "watchdog");
  end

endmodule
